// File: rtl/bist_engine.sv
// Built-in self-test engine: an LFSR drives the external CUT, a MISR compacts its responses,
// and the signature is compared against GOLDEN. Define BIST_SIG_OUT_EN to expose the MISR as sig_out.
module bist_engine #(
  parameter int               IN_W      = 3,
  parameter int               OUT_W     = 2,
  parameter int               SIG_W     = 4,
  parameter int               PATTERNS  = 7,
  parameter logic [IN_W-1:0]  LFSR_TAPS = 3'b101,
  parameter logic [SIG_W-1:0] MISR_TAPS = 4'b1001,
  parameter logic [IN_W-1:0]  SEED      = 1,
  parameter logic [SIG_W-1:0] GOLDEN    = 4'b0011
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             testmode,
  input  logic             start,
  input  logic [IN_W-1:0]  func_in,
  output logic [IN_W-1:0]  cut_in,
  input  logic [OUT_W-1:0] cut_out,
  output logic             busy,
  output logic             done,
  output logic             fault_detected
`ifdef BIST_SIG_OUT_EN
  ,
  output logic [SIG_W-1:0] sig_out
`endif
);

  localparam int CNT_W = (PATTERNS < 2) ? 1 : $clog2(PATTERNS + 1);
  // An all-zero LFSR state would lock up, so a zero seed is promoted to 1.
  localparam logic [IN_W-1:0]  SEED_EFF = (SEED == '0) ? IN_W'(1) : SEED;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PATTERNS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state;
  logic [IN_W-1:0]  lfsr;
  logic [SIG_W-1:0] misr;
  logic [CNT_W-1:0] count;

  function automatic logic [IN_W-1:0] lfsr_step(input logic [IN_W-1:0] s);
    return {s[IN_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                 input logic [OUT_W-1:0] r);
    return {s[SIG_W-2:0], ^(s & MISR_TAPS)} ^ SIG_W'(r);
  endfunction

  assign cut_in = testmode ? lfsr : func_in;

`ifdef BIST_SIG_OUT_EN
  // MISR only moves in RUN and is cleared on start/reset, so it already has the hold semantics.
  assign sig_out = misr;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      lfsr           <= SEED_EFF;
      misr           <= '0;
      count          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      fault_detected <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!testmode) fault_detected <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && testmode) begin
            state          <= S_RUN;
            lfsr           <= SEED_EFF;
            misr           <= '0;
            count          <= '0;
            busy           <= 1'b1;
            fault_detected <= 1'b0;
          end
        end
        S_RUN: begin
          if (!testmode) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            misr  <= misr_step(misr, cut_out);
            lfsr  <= lfsr_step(lfsr);
            count <= count + 1'b1;
            if (count == LAST_CNT) state <= S_CHECK;
          end
        end
        S_CHECK: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          if (testmode) begin
            state          <= S_DONE;
            done           <= 1'b1;
            fault_detected <= (misr != GOLDEN);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bist_engine.sv
// Scoreboard bench for bist_engine: a 7-pattern instance and a 1-pattern instance driven by
// a full-adder CUT, with randomized runs, aborts, resets and stray start pulses.
module tb_bist_engine;

  typedef struct packed {
    bit         done;
    bit         fault;
    int         busy;
    logic [3:0] sig;
  } exp_t;

  localparam logic [3:0] GOLDEN0 = 4'b1011;
  localparam logic [3:0] GOLDEN1 = 4'b0001;
  localparam logic [2:0] SEQ [7] = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b101, 3'b010, 3'b100};

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       testmode = 1'b1;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [2:0] func_in = '0;
  logic       stuck_at0 = 1'b0;
  logic [2:0] cut_in0, cut_in1;
  logic [1:0] cut_out0, cut_out1;
  logic       busy0, busy1, done0, done1, fault0, fault1;
  logic [3:0] sig0, sig1;

  int  n_cmp = 0;
  int  n_fail = 0;
  exp_t q0[$];
  exp_t q1[$];
  bit  armed = 0;
  bit  rst_edge = 0, tm_edge = 1;
  bit  prev_busy [2] = '{0, 0};
  int  bcnt [2] = '{0, 0};
  bit  held [2] = '{0, 0};

  always #5 clock = ~clock;

  bist_engine #(.PATTERNS(7), .GOLDEN(GOLDEN0)) dut0 (
    .clock(clock), .reset(reset), .testmode(testmode), .start(start0), .func_in(func_in),
    .cut_in(cut_in0), .cut_out(cut_out0), .busy(busy0), .done(done0), .fault_detected(fault0)
`ifdef BIST_SIG_OUT_EN
    , .sig_out(sig0)
`endif
  );

  bist_engine #(.PATTERNS(1), .GOLDEN(GOLDEN1)) dut1 (
    .clock(clock), .reset(reset), .testmode(testmode), .start(start1), .func_in(func_in),
    .cut_in(cut_in1), .cut_out(cut_out1), .busy(busy1), .done(done1), .fault_detected(fault1)
`ifdef BIST_SIG_OUT_EN
    , .sig_out(sig1)
`endif
  );

`ifndef BIST_SIG_OUT_EN
  assign sig0 = '0;
  assign sig1 = '0;
`endif

  // Full-adder CUT: cut_out = {carry, sum}, with an optional stuck-at-0 on the sum bit.
  always_comb begin
    cut_out0[1] = (cut_in0[0] & cut_in0[1]) | (cut_in0[0] & cut_in0[2]) | (cut_in0[1] & cut_in0[2]);
    cut_out0[0] = (^cut_in0) & ~stuck_at0;
    cut_out1[1] = (cut_in1[0] & cut_in1[1]) | (cut_in1[0] & cut_in1[2]) | (cut_in1[1] & cut_in1[2]);
    cut_out1[0] = (^cut_in1) & ~stuck_at0;
  end

  function automatic logic [3:0] model_sig(input int p, input bit stuck);
    int m, ones, resp, fb;
    m = 0;
    for (int k = 0; k < p; k++) begin
      ones = $countones(SEQ[k]);
      resp = ((ones >= 2) ? 2 : 0) + (stuck ? 0 : ones % 2);
      fb   = $countones(m & 9) % 2;
      m    = (((m * 2) + fb) % 16) ^ resp;
    end
    return 4'(m);
  endfunction

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t make_exp(input int p, input logic [3:0] g, input bit stuck, input int intr);
    exp_t e;
    e.sig = model_sig(p, stuck);
    if (intr >= 0 && intr <= p) begin
      e.done = 0; e.fault = 0; e.busy = intr + 1;
    end else begin
      e.done = 1; e.fault = (e.sig != g); e.busy = p + 1;
    end
    return e;
  endfunction

  always @(posedge clock) begin
    rst_edge <= reset;
    tm_edge  <= testmode;
  end

  task automatic mon(input int i, input int p, input logic [2:0] ci, input logic b, input logic d,
                     input logic f, input logic [3:0] s);
    exp_t e;
    int   qs;
    if (b) bcnt[i] = prev_busy[i] ? bcnt[i] + 1 : 0;
    if (!testmode) check(ci == func_in, "cut_in_func", ci, func_in);
    else if (b && bcnt[i] < p) check(ci == SEQ[bcnt[i]], "cut_in_lfsr", ci, SEQ[bcnt[i]]);
    if (rst_edge) check({b, d, f} == 3'b000, "reset_outputs", {b, d, f}, 0);
    if (b) begin
      check({d, f} == 2'b00, "busy_flags", {d, f}, 0);
      check(bcnt[i] <= p, "busy_len", bcnt[i], p);
    end else if (prev_busy[i]) begin
      qs = (i == 0) ? q0.size() : q1.size();
      check(qs != 0, "run_expected", qs, 1);
      if (qs != 0) begin
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        check(d == e.done, "done_at_end", d, e.done);
        check(f == e.fault, "fault_at_end", f, e.fault);
        check(bcnt[i] + 1 == e.busy, "busy_cycles", bcnt[i] + 1, e.busy);
`ifdef BIST_SIG_OUT_EN
        if (e.done) check(s == e.sig, "sig_out", s, e.sig);
`endif
        held[i] = e.fault;
      end
    end else begin
      if (rst_edge || !tm_edge) held[i] = 0;
      check(f == held[i], "fault_hold", f, held[i]);
      check(!d, "done_idle", d, 0);
    end
    prev_busy[i] = b;
  endtask

  always @(negedge clock) begin
    if (rst_edge) armed = 1;
    if (armed) begin
      mon(0, 7, cut_in0, busy0, done0, fault0, sig0);
      mon(1, 1, cut_in1, busy1, done1, fault1, sig1);
    end
  end

  task automatic do_run(input bit stuck, input int abort_at, input int rst_at, input bit noise,
                        input bit hold);
    int  intr;
    bit  allowed;
    intr = (abort_at >= 0) ? abort_at : rst_at;
    stuck_at0 = stuck;
    testmode  = 1'b1;
    reset     = 1'b0;
    start0    = 1'b1;
    start1    = 1'b1;
    q0.push_back(make_exp(7, GOLDEN0, stuck, intr));
    q1.push_back(make_exp(1, GOLDEN1, stuck, intr));
    @(posedge clock); #1;
    for (int k = 0; k < 9; k++) begin
      func_in = 3'($urandom);
      reset   = (k == rst_at);
      if (k == abort_at) testmode = 1'b0;
      allowed = (intr < 0) || (k <= intr);
      start0  = allowed && (hold || (noise && $urandom_range(0, 1) == 1));
      start1  = allowed && (k < 3) && (hold || (noise && $urandom_range(0, 1) == 1));
      @(posedge clock); #1;
    end
    reset  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic idle(input int n, input bit drop);
    for (int k = 0; k < n; k++) begin
      func_in  = 3'($urandom);
      testmode = !(drop && k == 0);
      @(posedge clock); #1;
    end
  endtask

  initial begin
    int ab, rs, sel;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    idle(2, 0);

    do_run(0, -1, -1, 0, 0);  idle(2, 0);
    do_run(1, -1, -1, 0, 0);  idle(3, 0);
    do_run(0, -1, -1, 0, 0);  idle(2, 0);
    do_run(0,  2, -1, 0, 0);  idle(3, 1);
    do_run(1, -1, -1, 1, 0);  idle(2, 1);
    do_run(0, -1,  3, 0, 0);  idle(1, 0);
    do_run(0, -1, -1, 0, 0);  idle(2, 0);
    do_run(0, -1, -1, 0, 1);  idle(3, 0);

    for (int r = 0; r < 30; r++) begin
      sel = $urandom_range(0, 9);
      ab  = -1;
      rs  = -1;
      if (sel < 3) ab = $urandom_range(0, 7);
      else if (sel == 3) rs = $urandom_range(0, 8);
      do_run($urandom_range(0, 1) == 1, ab, rs, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
      idle($urandom_range(1, 4), $urandom_range(0, 2) == 0);
    end

    idle(4, 0);
    check(q0.size() == 0, "pending_runs0", q0.size(), 0);
    check(q1.size() == 0, "pending_runs1", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
